// File: rtl/rs_pkg.sv
// Shared definitions for the reservation station.
//   - Default operand, tag and control widths.
//   - Lane packing helper for the flattened CDB and issue buses.
//   - Bit offsets of the fields inside one packed entry word.
package rs_pkg;

  localparam int unsigned RS_TAG_W  = 5;
  localparam int unsigned RS_DATA_W = 32;
  localparam int unsigned RS_CTRL_W = 9;

  // Fields of a packed entry word, listed from LSB upwards.
  typedef enum logic [2:0] {
    F_TAG1,
    F_TAG2,
    F_VAL1,
    F_VAL2,
    F_DEST,
    F_CTRL
  } ent_field_e;

  // Lane n of a flattened bus of width-wide lanes starts at n*width.
  function automatic int unsigned lane_lsb(input int unsigned lane,
                                           input int unsigned width);
    return lane * width;
  endfunction

  function automatic int unsigned ent_off(input ent_field_e f,
                                          input int unsigned tag_w,
                                          input int unsigned data_w);
    int unsigned off;
    case (f)
      F_TAG1:  off = 0;
      F_TAG2:  off = tag_w;
      F_VAL1:  off = 2 * tag_w;
      F_VAL2:  off = 2 * tag_w + data_w;
      F_DEST:  off = 2 * tag_w + 2 * data_w;
      default: off = 3 * tag_w + 2 * data_w;
    endcase
    return off;
  endfunction

  function automatic int unsigned ent_width(input int unsigned tag_w,
                                            input int unsigned data_w,
                                            input int unsigned ctrl_w);
    return 3 * tag_w + 2 * data_w + ctrl_w;
  endfunction

endpackage

// File: rtl/rs_station_param_if.sv
// Allocation, CDB wakeup and issue signals of the reservation station.
//   master: producer side (rename stage, CDB, ALU cluster) - drives alloc_*,
//           cdb_* and iss_ready; observes alloc_ready and iss_* payload.
//   slave : the reservation station itself.
// CDB and issue buses are flattened; lane n sits at [n*W +: W].
interface rs_station_param_if
  import rs_pkg::*;
#(
  parameter int unsigned NUM_CDB   = 2,
  parameter int unsigned NUM_ISSUE = 2,
  parameter int unsigned TAG_W     = RS_TAG_W,
  parameter int unsigned DATA_W    = RS_DATA_W,
  parameter int unsigned CTRL_W    = RS_CTRL_W
);

  logic                          alloc_valid;
  logic                          alloc_ready;
  logic [CTRL_W-1:0]             alloc_ctrl;
  logic [TAG_W-1:0]              alloc_dest;
  logic                          alloc_src1_rdy;
  logic                          alloc_src2_rdy;
  logic [TAG_W-1:0]              alloc_src1_tag;
  logic [TAG_W-1:0]              alloc_src2_tag;
  logic [DATA_W-1:0]             alloc_src1_val;
  logic [DATA_W-1:0]             alloc_src2_val;

  logic [NUM_CDB-1:0]            cdb_valid;
  logic [NUM_CDB*TAG_W-1:0]      cdb_tag;
  logic [NUM_CDB*DATA_W-1:0]     cdb_data;

  logic [NUM_ISSUE-1:0]          iss_valid;
  logic [NUM_ISSUE-1:0]          iss_ready;
  logic [NUM_ISSUE*CTRL_W-1:0]   iss_ctrl;
  logic [NUM_ISSUE*TAG_W-1:0]    iss_dest;
  logic [NUM_ISSUE*DATA_W-1:0]   iss_op1;
  logic [NUM_ISSUE*DATA_W-1:0]   iss_op2;

  modport master (
    output alloc_valid, alloc_ctrl, alloc_dest,
           alloc_src1_rdy, alloc_src2_rdy,
           alloc_src1_tag, alloc_src2_tag,
           alloc_src1_val, alloc_src2_val,
           cdb_valid, cdb_tag, cdb_data, iss_ready,
    input  alloc_ready, iss_valid, iss_ctrl, iss_dest, iss_op1, iss_op2
  );

  modport slave (
    input  alloc_valid, alloc_ctrl, alloc_dest,
           alloc_src1_rdy, alloc_src2_rdy,
           alloc_src1_tag, alloc_src2_tag,
           alloc_src1_val, alloc_src2_val,
           cdb_valid, cdb_tag, cdb_data, iss_ready,
    output alloc_ready, iss_valid, iss_ctrl, iss_dest, iss_op1, iss_op2
  );

endinterface

// File: rtl/rs_age_select.sv
// Oldest-first selector.
//   elig  : entries that may issue this cycle.
//   older : flattened age matrix, bit [i*DEPTH+j] set when entry i is older
//           than entry j (only meaningful between live entries).
//   gnt0  : one-hot oldest eligible entry (zero when none).
//   gnt1  : one-hot second-oldest eligible entry (zero when fewer than two).
module rs_age_select #(
  parameter int unsigned DEPTH = 8
) (
  input  logic [DEPTH-1:0]       elig,
  input  logic [DEPTH*DEPTH-1:0] older,
  output logic [DEPTH-1:0]       gnt0,
  output logic [DEPTH-1:0]       gnt1
);

  // A candidate wins when it is older than every other candidate.
  function automatic logic [DEPTH-1:0] pick_oldest(
    input logic [DEPTH-1:0]       cand,
    input logic [DEPTH*DEPTH-1:0] age
  );
    logic [DEPTH-1:0] g;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      g[i] = cand[i];
      for (int unsigned j = 0; j < DEPTH; j++) begin
        if (j != i && cand[j] && !age[i*DEPTH+j]) begin
          g[i] = 1'b0;
        end
      end
    end
    return g;
  endfunction

  assign gnt0 = pick_oldest(elig, older);
  assign gnt1 = pick_oldest(elig & ~gnt0, older);

endmodule

// File: rtl/rs_station_param.sv
// Parametrised reservation station between rename/ROB-allocate and the ALUs.
//   clk   : rising-edge clock.
//   rst   : asynchronous active-low reset.
//   flush : discard every entry; blocks alloc and issue in that cycle.
//   bus   : slave side of rs_station_param_if (alloc handshake, NUM_CDB
//           wakeup buses, NUM_ISSUE issue ports with payload).
//   count : number of occupied entries.
// Entries wake from the CDB (also in the allocation cycle), and the oldest
// ready entries are offered on port 0 then port 1.
module rs_station_param
  import rs_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned NUM_CDB   = 2,
  parameter int unsigned NUM_ISSUE = 2,
  parameter int unsigned TAG_W     = RS_TAG_W,
  parameter int unsigned DATA_W    = RS_DATA_W,
  parameter int unsigned CTRL_W    = RS_CTRL_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  rs_station_param_if.slave          bus,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned ENT_W  = ent_width(TAG_W, DATA_W, CTRL_W);
  localparam int unsigned O_TAG1 = ent_off(F_TAG1, TAG_W, DATA_W);
  localparam int unsigned O_TAG2 = ent_off(F_TAG2, TAG_W, DATA_W);
  localparam int unsigned O_VAL1 = ent_off(F_VAL1, TAG_W, DATA_W);
  localparam int unsigned O_VAL2 = ent_off(F_VAL2, TAG_W, DATA_W);
  localparam int unsigned O_DEST = ent_off(F_DEST, TAG_W, DATA_W);
  localparam int unsigned O_CTRL = ent_off(F_CTRL, TAG_W, DATA_W);

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] rdy1;
  logic [DEPTH-1:0] rdy2;
  logic [ENT_W-1:0] ent   [DEPTH];
  logic [DEPTH-1:0] older [DEPTH];
  logic [CNT_W-1:0] count_q;

  logic             alloc_ready;
  logic             alloc_fire;
  logic [DEPTH-1:0] alloc_sel;
  logic             slot_found;

  logic [DATA_W:0]  wake1 [DEPTH];
  logic [DATA_W:0]  wake2 [DEPTH];
  logic [DATA_W:0]  new1;
  logic [DATA_W:0]  new2;

  logic [DEPTH-1:0]       elig;
  logic [DEPTH*DEPTH-1:0] age_flat;
  logic [DEPTH-1:0]       gnt0;
  logic [DEPTH-1:0]       gnt1;
  logic [DEPTH-1:0]       g;
  logic [DEPTH-1:0]       free_vec;
  logic [NUM_ISSUE-1:0]   iss_valid;
  logic [NUM_ISSUE-1:0]   acc;
  logic [CNT_W-1:0]       n_acc;
  logic [CTRL_W-1:0]      sel_ctrl;
  logic [TAG_W-1:0]       sel_dest;
  logic [DATA_W-1:0]      sel_op1;
  logic [DATA_W-1:0]      sel_op2;

  // Returns {hit, data}; the lowest-numbered matching bus wins because the
  // scan runs from the highest bus down and the last hit overwrites.
  function automatic logic [DATA_W:0] cdb_match(
    input logic [TAG_W-1:0]          tag,
    input logic [NUM_CDB-1:0]        v,
    input logic [NUM_CDB*TAG_W-1:0]  tags,
    input logic [NUM_CDB*DATA_W-1:0] data
  );
    logic [DATA_W:0] r;
    int unsigned     b;
    r = '0;
    for (int unsigned k = 0; k < NUM_CDB; k++) begin
      b = NUM_CDB - 1 - k;
      if (v[b] && tags[lane_lsb(b, TAG_W) +: TAG_W] == tag) begin
        r = {1'b1, data[lane_lsb(b, DATA_W) +: DATA_W]};
      end
    end
    return r;
  endfunction

  assign count       = count_q;
  assign alloc_ready = (count_q < CNT_W'(DEPTH)) && !flush;
  assign alloc_fire  = bus.alloc_valid && alloc_ready;
  assign bus.alloc_ready = alloc_ready;
  assign elig        = busy & rdy1 & rdy2;

  // Lowest-index free slot, one-hot.
  always_comb begin
    alloc_sel  = '0;
    slot_found = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!busy[i] && !slot_found) begin
        alloc_sel[i] = 1'b1;
        slot_found   = 1'b1;
      end
    end
  end

  always_comb begin
    new1 = cdb_match(bus.alloc_src1_tag, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
    new2 = cdb_match(bus.alloc_src2_tag, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      wake1[i] = cdb_match(ent[i][O_TAG1 +: TAG_W], bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
      wake2[i] = cdb_match(ent[i][O_TAG2 +: TAG_W], bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
    end
  end

  always_comb begin
    age_flat = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      for (int unsigned j = 0; j < DEPTH; j++) begin
        age_flat[i*DEPTH+j] = older[i][j];
      end
    end
  end

  rs_age_select #(
    .DEPTH (DEPTH)
  ) u_age_select (
    .elig  (elig),
    .older (age_flat),
    .gnt0  (gnt0),
    .gnt1  (gnt1)
  );

  // Issue ports: payload is OR-muxed from the one-hot grant and forced to
  // zero whenever the port is not valid.
  always_comb begin
    free_vec     = '0;
    n_acc        = '0;
    iss_valid    = '0;
    acc          = '0;
    g            = '0;
    sel_ctrl     = '0;
    sel_dest     = '0;
    sel_op1      = '0;
    sel_op2      = '0;
    bus.iss_ctrl = '0;
    bus.iss_dest = '0;
    bus.iss_op1  = '0;
    bus.iss_op2  = '0;
    for (int unsigned p = 0; p < NUM_ISSUE; p++) begin
      g            = (p == 0) ? gnt0 : gnt1;
      iss_valid[p] = (|g) && !flush;
      acc[p]       = iss_valid[p] && bus.iss_ready[p];
      if (acc[p]) begin
        free_vec = free_vec | g;
      end
      n_acc    = n_acc + CNT_W'(acc[p]);
      sel_ctrl = '0;
      sel_dest = '0;
      sel_op1  = '0;
      sel_op2  = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (iss_valid[p] && g[i]) begin
          sel_ctrl = sel_ctrl | ent[i][O_CTRL +: CTRL_W];
          sel_dest = sel_dest | ent[i][O_DEST +: TAG_W];
          sel_op1  = sel_op1  | ent[i][O_VAL1 +: DATA_W];
          sel_op2  = sel_op2  | ent[i][O_VAL2 +: DATA_W];
        end
      end
      bus.iss_ctrl[lane_lsb(p, CTRL_W) +: CTRL_W] = sel_ctrl;
      bus.iss_dest[lane_lsb(p, TAG_W)  +: TAG_W]  = sel_dest;
      bus.iss_op1[lane_lsb(p, DATA_W)  +: DATA_W] = sel_op1;
      bus.iss_op2[lane_lsb(p, DATA_W)  +: DATA_W] = sel_op2;
    end
  end

  assign bus.iss_valid = iss_valid;

  // Control state: occupancy, operand-ready flags and age matrix.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy    <= '0;
      rdy1    <= '0;
      rdy2    <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        older[i] <= '0;
      end
    end else if (flush) begin
      busy    <= '0;
      rdy1    <= '0;
      rdy2    <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        older[i] <= '0;
      end
    end else begin
      count_q <= count_q + CNT_W'(alloc_fire) - n_acc;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (alloc_fire && alloc_sel[i]) begin
          busy[i]  <= 1'b1;
          rdy1[i]  <= bus.alloc_src1_rdy || new1[DATA_W];
          rdy2[i]  <= bus.alloc_src2_rdy || new2[DATA_W];
          older[i] <= '0;
        end else if (free_vec[i]) begin
          busy[i] <= 1'b0;
          rdy1[i] <= 1'b0;
          rdy2[i] <= 1'b0;
        end else if (busy[i]) begin
          if (!rdy1[i] && wake1[i][DATA_W]) rdy1[i] <= 1'b1;
          if (!rdy2[i] && wake2[i][DATA_W]) rdy2[i] <= 1'b1;
        end
      end
      // The new entry's row is cleared above; here every currently busy
      // entry is marked older than it. The diagonal is never set.
      for (int unsigned j = 0; j < DEPTH; j++) begin
        for (int unsigned k = 0; k < DEPTH; k++) begin
          if (alloc_fire && alloc_sel[k] && j != k) begin
            older[j][k] <= busy[j];
          end
        end
      end
    end
  end

  // Entry payload needs no reset: it is only visible through a valid grant.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (alloc_fire && alloc_sel[i]) begin
        ent[i][O_CTRL +: CTRL_W] <= bus.alloc_ctrl;
        ent[i][O_DEST +: TAG_W]  <= bus.alloc_dest;
        ent[i][O_TAG1 +: TAG_W]  <= bus.alloc_src1_tag;
        ent[i][O_TAG2 +: TAG_W]  <= bus.alloc_src2_tag;
        ent[i][O_VAL1 +: DATA_W] <= bus.alloc_src1_rdy ? bus.alloc_src1_val : new1[DATA_W-1:0];
        ent[i][O_VAL2 +: DATA_W] <= bus.alloc_src2_rdy ? bus.alloc_src2_val : new2[DATA_W-1:0];
      end else if (!flush && busy[i]) begin
        if (!rdy1[i] && wake1[i][DATA_W]) ent[i][O_VAL1 +: DATA_W] <= wake1[i][DATA_W-1:0];
        if (!rdy2[i] && wake2[i][DATA_W]) ent[i][O_VAL2 +: DATA_W] <= wake2[i][DATA_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_rs_station_param.sv
// Directed scoreboard bench for rs_station_param (DEPTH=8, 2 CDB, 2 issue).
module tb_rs_station_param;
  import rs_pkg::*;

  logic       clk;
  logic       rst;
  logic       flush;
  logic [3:0] count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [8:0]  ctrl;
    logic [4:0]  dest;
    logic [31:0] op1;
    logic [31:0] op2;
  } rec_t;

  rec_t exp_q[$];

  rs_station_param_if #(
    .NUM_CDB   (2),
    .NUM_ISSUE (2),
    .TAG_W     (5),
    .DATA_W    (32),
    .CTRL_W    (9)
  ) ifc ();

  rs_station_param #(
    .DEPTH     (8),
    .NUM_CDB   (2),
    .NUM_ISSUE (2),
    .TAG_W     (5),
    .DATA_W    (32),
    .CTRL_W    (9)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (ifc),
    .count (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [8:0] c, input logic [4:0] d,
                          input logic [31:0] a, input logic [31:0] b);
    rec_t r;
    r.ctrl = c; r.dest = d; r.op1 = a; r.op2 = b;
    exp_q.push_back(r);
  endtask

  task automatic drive_alloc(input logic v, input logic [8:0] c, input logic [4:0] d,
                             input logic r1, input logic [4:0] t1, input logic [31:0] v1,
                             input logic r2, input logic [4:0] t2, input logic [31:0] v2);
    ifc.alloc_valid    = v;
    ifc.alloc_ctrl     = c;
    ifc.alloc_dest     = d;
    ifc.alloc_src1_rdy = r1;
    ifc.alloc_src1_tag = t1;
    ifc.alloc_src1_val = v1;
    ifc.alloc_src2_rdy = r2;
    ifc.alloc_src2_tag = t2;
    ifc.alloc_src2_val = v2;
  endtask

  task automatic drive_cdb(input logic [1:0] v, input logic [4:0] t0, input logic [31:0] d0,
                           input logic [4:0] t1, input logic [31:0] d1);
    ifc.cdb_valid = v;
    ifc.cdb_tag   = {t1, t0};
    ifc.cdb_data  = {d1, d0};
  endtask

  // Accept on the ports in mask at the next edge; each accepted port pops
  // the scoreboard (port 0 first) and its payload is compared.
  task automatic accept(input logic [1:0] mask);
    rec_t r;
    ifc.iss_ready = mask;
    #1;
    for (int p = 0; p < 2; p++) begin
      if (mask[p]) begin
        chk($sformatf("iss_valid_p%0d", p), 64'(ifc.iss_valid[p]), 64'd1);
        chk("scoreboard_nonempty", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          r = exp_q.pop_front();
          chk($sformatf("iss_ctrl_p%0d", p), 64'(ifc.iss_ctrl[p*9 +: 9]), 64'(r.ctrl));
          chk($sformatf("iss_dest_p%0d", p), 64'(ifc.iss_dest[p*5 +: 5]), 64'(r.dest));
          chk($sformatf("iss_op1_p%0d", p),  64'(ifc.iss_op1[p*32 +: 32]), 64'(r.op1));
          chk($sformatf("iss_op2_p%0d", p),  64'(ifc.iss_op2[p*32 +: 32]), 64'(r.op2));
        end
      end
    end
    tick();
    ifc.iss_ready = '0;
  endtask

  initial begin
    rst   = 1'b0;
    flush = 1'b0;
    drive_alloc(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, '0);
    drive_cdb(2'b00, '0, '0, '0, '0);
    ifc.iss_ready = '0;

    // Reset state
    repeat (3) tick();
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_iss_valid", 64'(ifc.iss_valid), 64'd0);
    chk("reset_iss_dest", 64'(ifc.iss_dest), 64'd0);
    chk("reset_iss_op1", 64'(ifc.iss_op1), 64'd0);
    chk("reset_iss_ctrl", 64'(ifc.iss_ctrl), 64'd0);
    rst = 1'b1;
    #1;
    chk("reset_alloc_ready", 64'(ifc.alloc_ready), 64'd1);

    // Both operands ready at allocation
    tick();
    drive_alloc(1'b1, 9'h012, 5'd3, 1'b1, 5'd0, 32'd5, 1'b1, 5'd0, 32'd7);
    #1;
    chk("t1_alloc_ready", 64'(ifc.alloc_ready), 64'd1);
    chk("t1_no_issue_same_cycle", 64'(ifc.iss_valid), 64'd0);
    tick();
    ifc.alloc_valid = 1'b0;
    #1;
    chk("t1_count", 64'(count), 64'd1);
    chk("t1_iss_valid", 64'(ifc.iss_valid), 64'b01);
    chk("t1_port1_dest_zero", 64'(ifc.iss_dest[9:5]), 64'd0);
    push_exp(9'h012, 5'd3, 32'd5, 32'd7);
    accept(2'b01);
    chk("t1_count_after_issue", 64'(count), 64'd0);

    // Same-cycle CDB capture at allocation, tag 0, duplicate tag on bus 1
    drive_alloc(1'b1, 9'h021, 5'd4, 1'b0, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'h55);
    drive_cdb(2'b11, 5'd0, 32'hAA, 5'd0, 32'hBB);
    tick();
    drive_alloc(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, '0);
    drive_cdb(2'b00, '0, '0, '0, '0);
    #1;
    chk("t2_count", 64'(count), 64'd1);
    chk("t2_iss_valid", 64'(ifc.iss_valid), 64'b01);
    push_exp(9'h021, 5'd4, 32'hAA, 32'h55);
    accept(2'b01);
    chk("t2_count_after_issue", 64'(count), 64'd0);

    // Fill with pending tags 1..8 (slot i-1 holds tag i)
    for (int i = 1; i <= 8; i++) begin
      drive_alloc(1'b1, 9'(i), 5'(10 + i), 1'b0, 5'(i), '0, 1'b1, '0, 32'(256 + i));
      #1;
      chk($sformatf("fill_alloc_ready_%0d", i), 64'(ifc.alloc_ready), 64'd1);
      tick();
    end
    // Alloc attempt while full plus wakeup of tags 8 (bus 0) and 2 (bus 1)
    drive_alloc(1'b1, 9'h1EE, 5'd31, 1'b1, '0, 32'h1, 1'b1, '0, 32'h2);
    drive_cdb(2'b11, 5'd8, 32'hD8, 5'd2, 32'hD2);
    #1;
    chk("full_count", 64'(count), 64'd8);
    chk("full_alloc_ready", 64'(ifc.alloc_ready), 64'd0);
    chk("no_bypass_iss_valid", 64'(ifc.iss_valid), 64'd0);
    tick();
    drive_alloc(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, '0);
    drive_cdb(2'b00, '0, '0, '0, '0);
    #1;
    chk("full_alloc_ignored", 64'(count), 64'd8);
    chk("wake_iss_valid", 64'(ifc.iss_valid), 64'b11);
    chk("port0_oldest_dest", 64'(ifc.iss_dest[4:0]), 64'd12);

    // Port 1 accepts while port 0 stalls
    push_exp(9'd8, 5'd18, 32'hD8, 32'd264);
    accept(2'b10);
    chk("p1_only_count", 64'(count), 64'd7);
    chk("p1_only_alloc_ready", 64'(ifc.alloc_ready), 64'd1);
    chk("p1_only_iss_valid", 64'(ifc.iss_valid), 64'b01);
    push_exp(9'd2, 5'd12, 32'hD2, 32'd258);
    accept(2'b01);
    chk("after_p0_count", 64'(count), 64'd6);

    // Wake tags 3 and 4, then issue + allocate in the same cycle
    drive_cdb(2'b11, 5'd3, 32'hC3, 5'd4, 32'hC4);
    tick();
    drive_cdb(2'b00, '0, '0, '0, '0);
    #1;
    chk("t5_iss_valid", 64'(ifc.iss_valid), 64'b11);
    drive_alloc(1'b1, 9'h1FF, 5'd20, 1'b1, '0, 32'd1, 1'b1, '0, 32'd2);
    #1;
    chk("t5_alloc_ready", 64'(ifc.alloc_ready), 64'd1);
    push_exp(9'd3, 5'd13, 32'hC3, 32'd259);
    accept(2'b01);
    drive_alloc(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, '0);
    #1;
    chk("alloc_and_issue_count", 64'(count), 64'd6);
    chk("t5b_iss_valid", 64'(ifc.iss_valid), 64'b11);
    chk("age_not_index_p0", 64'(ifc.iss_dest[4:0]), 64'd14);
    push_exp(9'h1FF, 5'd20, 32'd1, 32'd2);
    accept(2'b10);
    chk("pre_flush_count", 64'(count), 64'd5);
    chk("pre_flush_iss_valid", 64'(ifc.iss_valid), 64'b01);

    // Flush beats alloc, issue and CDB
    flush = 1'b1;
    drive_alloc(1'b1, 9'h033, 5'd9, 1'b1, '0, 32'd9, 1'b1, '0, 32'd9);
    drive_cdb(2'b01, 5'd1, 32'hF1, '0, '0);
    ifc.iss_ready = 2'b11;
    #1;
    chk("flush_iss_valid", 64'(ifc.iss_valid), 64'd0);
    chk("flush_alloc_ready", 64'(ifc.alloc_ready), 64'd0);
    chk("flush_payload_zero", 64'(ifc.iss_dest), 64'd0);
    tick();
    flush = 1'b0;
    ifc.iss_ready = '0;
    drive_alloc(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, '0);
    drive_cdb(2'b00, '0, '0, '0, '0);
    #1;
    chk("post_flush_count", 64'(count), 64'd0);
    chk("post_flush_iss_valid", 64'(ifc.iss_valid), 64'd0);
    chk("post_flush_alloc_ready", 64'(ifc.alloc_ready), 64'd1);

    // Asynchronous reset mid-operation
    drive_alloc(1'b1, 9'h044, 5'd25, 1'b1, '0, 32'd3, 1'b1, '0, 32'd4);
    tick();
    tick();
    ifc.alloc_valid = 1'b0;
    #1;
    chk("pre_reset_count", 64'(count), 64'd2);
    chk("pre_reset_iss_valid", 64'(ifc.iss_valid), 64'b11);
    rst = 1'b0;
    #1;
    chk("async_reset_count", 64'(count), 64'd0);
    chk("async_reset_iss_valid", 64'(ifc.iss_valid), 64'd0);
    chk("async_reset_op1", 64'(ifc.iss_op1), 64'd0);
    tick();
    rst = 1'b1;
    #1;
    chk("after_reset_alloc_ready", 64'(ifc.alloc_ready), 64'd1);

    // Stored-entry wakeup from bus 1, no same-cycle bypass
    drive_alloc(1'b1, 9'h0AB, 5'd31, 1'b0, 5'd5, '0, 1'b1, '0, 32'h77);
    tick();
    drive_alloc(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, '0);
    drive_cdb(2'b10, '0, '0, 5'd5, 32'hE5);
    #1;
    chk("pending_not_valid", 64'(ifc.iss_valid), 64'd0);
    tick();
    drive_cdb(2'b00, '0, '0, '0, '0);
    push_exp(9'h0AB, 5'd31, 32'hE5, 32'h77);
    accept(2'b01);
    chk("final_count", 64'(count), 64'd0);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
